// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns a symbolic instruction request into a 32-bit MIPS
// machine word for an instruction-memory loader. Every emitted word is paired
// with an auto-incrementing word address. The LI pseudo-instruction expands
// into one word (ORI or LUI) or two words (LUI then ORI) via a small FSM.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge; ready may rise or fall freely and never depends on
// the same side's valid. Here in_ready depends only on FSM state, out_valid and
// out_ready, so no combinational path runs from in_valid to in_ready.
module mips_instr_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [31:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              dbg_state
);

  // Request kinds
  localparam logic [3:0] KIND_RTYPE = 4'd0;
  localparam logic [3:0] KIND_ADDI  = 4'd1;
  localparam logic [3:0] KIND_ANDI  = 4'd2;
  localparam logic [3:0] KIND_ORI   = 4'd3;
  localparam logic [3:0] KIND_LUI   = 4'd4;
  localparam logic [3:0] KIND_BEQ   = 4'd5;
  localparam logic [3:0] KIND_BNE   = 4'd6;
  localparam logic [3:0] KIND_LW    = 4'd7;
  localparam logic [3:0] KIND_SW    = 4'd8;
  localparam logic [3:0] KIND_J     = 4'd9;
  localparam logic [3:0] KIND_JAL   = 4'd10;
  localparam logic [3:0] KIND_JR    = 4'd11;
  localparam logic [3:0] KIND_LI    = 4'd12;
  localparam logic [3:0] KIND_NOP   = 4'd13;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    LI2  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pendingOri;

  // Combinational encoder outputs for the request currently on the inputs
  logic [31:0] encWord;
  logic [31:0] encSecond;
  logic        encTwoWords;
  logic        encIllegal;

  logic [15:0] immHi;
  logic [15:0] immLo;

  logic inXfer;
  logic outXfer;

  assign immHi     = in_imm[31:16];
  assign immLo     = in_imm[15:0];
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign inXfer    = in_valid && in_ready;
  assign outXfer   = out_valid && out_ready;
  assign dbg_state = state;

  // Encode the presented request into its first word and, for a split LI, the
  // trailing ORI word; unknown kinds are flagged instead of encoded.
  always_comb begin
    encWord     = 32'h0000_0000;
    encSecond   = 32'h0000_0000;
    encTwoWords = 1'b0;
    encIllegal  = 1'b0;
    case (in_kind)
      KIND_RTYPE: encWord = {OP_SPECIAL, in_rs, in_rt, in_rd, in_shamt, in_funct};
      KIND_ADDI:  encWord = {OP_ADDI, in_rs, in_rt, immLo};
      KIND_ANDI:  encWord = {OP_ANDI, in_rs, in_rt, immLo};
      KIND_ORI:   encWord = {OP_ORI, in_rs, in_rt, immLo};
      KIND_LUI:   encWord = {OP_LUI, REG_ZERO, in_rt, immLo};
      KIND_BEQ:   encWord = {OP_BEQ, in_rs, in_rt, immLo};
      KIND_BNE:   encWord = {OP_BNE, in_rs, in_rt, immLo};
      KIND_LW:    encWord = {OP_LW, in_rs, in_rt, immLo};
      KIND_SW:    encWord = {OP_SW, in_rs, in_rt, immLo};
      KIND_J:     encWord = {OP_J, in_target};
      KIND_JAL:   encWord = {OP_JAL, in_target};
      KIND_JR:    encWord = {OP_SPECIAL, in_rs, REG_ZERO, REG_ZERO, REG_ZERO, FUNCT_JR};
      KIND_LI: begin
        if (immHi == 16'h0000) begin
          // Small constant: a single ORI from $zero covers it.
          encWord = {OP_ORI, REG_ZERO, in_rt, immLo};
        end else if (immLo == 16'h0000) begin
          // Low half clear: LUI alone sets the full value.
          encWord = {OP_LUI, REG_ZERO, in_rt, immHi};
        end else begin
          // General case: LUI the high half, then OR in the low half.
          encWord     = {OP_LUI, REG_ZERO, in_rt, immHi};
          encSecond   = {OP_ORI, in_rt, in_rt, immLo};
          encTwoWords = 1'b1;
        end
      end
      KIND_NOP:   encWord = 32'h0000_0000;
      default:    encIllegal = 1'b1;
    endcase
  end

  // FSM plus the registered output stage, address counter and error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_word   <= 32'h0000_0000;
      out_addr   <= BASE_ADDR;
      err        <= 1'b0;
      pendingOri <= 32'h0000_0000;
    end else begin
      err <= 1'b0;

      // The address belongs to the word just handed over; advance past it.
      if (outXfer) begin
        out_addr <= out_addr + ADDR_ONE;
      end

      case (state)
        IDLE: begin
          if (inXfer) begin
            if (encIllegal) begin
              // Nothing is emitted; the output stage only drains.
              err <= 1'b1;
              if (outXfer) begin
                out_valid <= 1'b0;
              end
            end else begin
              out_valid <= 1'b1;
              out_word  <= encWord;
              if (encTwoWords) begin
                pendingOri <= encSecond;
                state      <= LI2;
              end
            end
          end else if (outXfer) begin
            out_valid <= 1'b0;
          end
        end

        LI2: begin
          // The LUI half is on the output; swap in the ORI once it is taken.
          if (outXfer) begin
            out_word <= pendingOri;
            state    <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
